// File: rtl/ppu_pkg.sv
// Shared types for the processor-to-PPU command path: command word layout,
// opcode names and a saturating counter helper.
package ppu_pkg;

  localparam int PPU_CMD_W = 32;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [19:0] arg;
  } ppu_cmd_t;

  // Opcodes 0xC-0xF are reserved and travel through the receiver untouched.
  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_DRAW_SHIP = 4'h1,
    OP_DRAW_HIT  = 4'h2,
    OP_DRAW_MISS = 4'h3,
    OP_CLEAR     = 4'h4,
    OP_TEXT      = 4'h5
  } ppu_op_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ppu_cmd_receiver_if.sv
// Bundle of the processor push side and the PPU valid/ready side of the
// command receiver; the slave modport is the receiver's view.
interface ppu_cmd_receiver_if #(
  parameter int DATA_W = 32
);

  logic              ppu_send;
  logic [DATA_W-1:0] ppu_data;
  logic              ppu_flush;
  logic              ppu_full;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [3:0]        cmd_x;
  logic [3:0]        cmd_y;
  logic [19:0]       cmd_arg;

  modport master (
    output ppu_send, ppu_data, ppu_flush, cmd_ready,
    input  ppu_full, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_arg
  );

  modport slave (
    input  ppu_send, ppu_data, ppu_flush, cmd_ready,
    output ppu_full, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_arg
  );

endinterface

// File: rtl/ppu_cmd_fifo.sv
// First-word-fall-through command FIFO: storage array, wrapping pointers,
// occupancy count and a registered full flag. Flush beats push and pop.
module ppu_cmd_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = PPU_CMD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              send,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic              full,
  output logic              push,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              full_q;
  logic              room;
  logic              pop;

  // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
  assign valid = (count != '0);
  assign room  = (count != FULL_CNT) | (valid & ready);
  assign pop   = valid & ready & ~flush;
  assign push  = send & room & ~flush;
  assign drop  = send & ~room & ~flush;
  assign full  = full_q;

  // Empty FIFO presents zeros rather than stale array contents.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      count  <= count_next;
      full_q <= (count_next == FULL_CNT);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Array contents carry no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ppu_cmd_receiver.sv
// PPU command receiver: buffers processor command words, splits the head word
// into draw fields and tracks overflow. Optional counters under PPU_RX_STATS_EN.
module ppu_cmd_receiver
  import ppu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = PPU_CMD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ppu_cmd_receiver_if.slave    bus,
  output logic                 overflow
`ifdef PPU_RX_STATS_EN
  ,
  output logic [15:0]          rx_count,
  output logic [15:0]          drop_count
`endif
);

  logic [DATA_W-1:0] head_word;
  ppu_cmd_t          head;
  logic              push;
  logic              drop;
  logic              overflow_q;

  ppu_cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.ppu_flush),
    .send    (bus.ppu_send),
    .wr_data (bus.ppu_data),
    .ready   (bus.cmd_ready),
    .rd_data (head_word),
    .valid   (bus.cmd_valid),
    .full    (bus.ppu_full),
    .push    (push),
    .drop    (drop)
  );

  assign head        = head_word;
  assign bus.cmd_op  = head.op;
  assign bus.cmd_x   = head.x;
  assign bus.cmd_y   = head.y;
  assign bus.cmd_arg = head.arg;
  assign overflow    = overflow_q;

  // Sticky until flush or reset so firmware can see a lost command later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.ppu_flush) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef PPU_RX_STATS_EN
  logic [15:0] rx_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else if (bus.ppu_flush) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) rx_cnt_q   <= sat_inc16(rx_cnt_q);
      if (drop) drop_cnt_q <= sat_inc16(drop_cnt_q);
    end
  end

  assign rx_count   = rx_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ppu_cmd_receiver.sv
// Directed, table-driven bench for ppu_cmd_receiver, with hand sequences for
// flush, full-rate wrap, async reset and (PPU_RX_STATS_EN) counter saturation.
module tb_ppu_cmd_receiver;

  logic clk;
  logic rst_n;
  logic overflow;
`ifdef PPU_RX_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        send;
    logic [31:0] data;
    logic        flush;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model[$];
  logic [31:0] words[8];

  ppu_cmd_receiver_if #(.DATA_W(32)) bus ();

  ppu_cmd_receiver #(
    .DEPTH  (8),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .overflow   (overflow)
`ifdef PPU_RX_STATS_EN
    ,
    .rx_count   (rx_count),
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] head_word();
    return {bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_arg};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic send, input logic [31:0] data,
                                input logic flush, input logic ready);
    bus.ppu_send  = send;
    bus.ppu_data  = data;
    bus.ppu_flush = flush;
    bus.cmd_ready = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic send, input logic [31:0] data, input logic flush,
                         input logic ready, input logic exp_valid, input logic [31:0] exp_word,
                         input logic exp_full, input logic exp_ovf);
    vec_t v;
    v.send = send;  v.data = data;  v.flush = flush;  v.ready = ready;
    v.exp_valid = exp_valid;  v.exp_word = exp_word;
    v.exp_full = exp_full;    v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endtask

  initial begin
    words = '{32'h1110_0001, 32'h2220_0002, 32'h3330_0003, 32'h4440_0004,
              32'h5550_0005, 32'h6660_0006, 32'hC770_0007, 32'hF880_0008};

    // Single word, then the 8-deep fill, a dropped 9th word and a full drain.
    add_vec(1, 32'h1230_0005, 0, 0, 1, 32'h1230_0005, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         0, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, words[k], 0, 0, 1, words[0], (k == 7), 0);
    add_vec(1, 32'h9990_0009, 0, 0, 1, words[0], 1, 1);
    for (int k = 0; k < 8; k++)
      add_vec(0, 32'h0, 0, 1, (k < 7), (k < 7) ? words[k+1] : 32'h0, 0, 1);

    bus.ppu_send = 0; bus.ppu_data = '0; bus.ppu_flush = 0; bus.cmd_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check_output("reset_full",  {31'd0, bus.ppu_full},  32'd0);
    check_output("reset_ovf",   {31'd0, overflow},      32'd0);
    check_output("reset_head",  head_word(),            32'd0);
`ifdef PPU_RX_STATS_EN
    check_output("reset_rx",   {16'd0, rx_count},   32'd0);
    check_output("reset_drop", {16'd0, drop_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].send, vecs[i].data, vecs[i].flush, vecs[i].ready);
      check_output($sformatf("vec%0d_valid", i), {31'd0, bus.cmd_valid}, {31'd0, vecs[i].exp_valid});
      check_output($sformatf("vec%0d_head", i),  head_word(),            vecs[i].exp_word);
      check_output($sformatf("vec%0d_full", i),  {31'd0, bus.ppu_full},  {31'd0, vecs[i].exp_full});
      check_output($sformatf("vec%0d_ovf", i),   {31'd0, overflow},      {31'd0, vecs[i].exp_ovf});
    end
`ifdef PPU_RX_STATS_EN
    check_output("stats_rx_after_fill",  {16'd0, rx_count},   32'd9);
    check_output("stats_drop_after_9th", {16'd0, drop_count}, 32'd1);
`endif

    // Flush with a simultaneous send: the flushed-cycle word must never surface.
    for (int k = 0; k < 3; k++) apply_stimulus(1, 32'h4000_0010 + k, 0, 0);
    check_output("pre_flush_head", head_word(), 32'h4000_0010);
    apply_stimulus(1, 32'h5DEA_DBEE, 1, 0);
    check_output("flush_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check_output("flush_ovf",   {31'd0, overflow},      32'd0);
    check_output("flush_head",  head_word(),            32'd0);
`ifdef PPU_RX_STATS_EN
    check_output("flush_rx",   {16'd0, rx_count},   32'd0);
    check_output("flush_drop", {16'd0, drop_count}, 32'd0);
`endif
    apply_stimulus(1, 32'h2AB0_0123, 0, 0);
    check_output("post_flush_head", head_word(), 32'h2AB0_0123);
    apply_stimulus(0, 32'h0, 0, 1);
    check_output("post_flush_empty", {31'd0, bus.cmd_valid}, 32'd0);

    // Hold full while pushing and popping every cycle across pointer wrap.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1, 32'hA000_0000 + k, 0, 0);
      model.push_back(32'hA000_0000 + k);
    end
    check_output("wrap_full_start", {31'd0, bus.ppu_full}, 32'd1);
    for (int j = 0; j < 20; j++) begin
      apply_stimulus(1, 32'hB000_0000 + j, 0, 1);
      void'(model.pop_front());
      model.push_back(32'hB000_0000 + j);
      check_output($sformatf("wrap%0d_full", j), {31'd0, bus.ppu_full}, 32'd1);
      check_output($sformatf("wrap%0d_head", j), head_word(),           model[0]);
      check_output($sformatf("wrap%0d_ovf", j),  {31'd0, overflow},     32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(0, 32'h0, 0, 1);
      void'(model.pop_front());
      check_output($sformatf("wrap_drain%0d_head", k), head_word(),
                   (model.size() != 0) ? model[0] : 32'h0);
    end
    check_output("wrap_drain_valid", {31'd0, bus.cmd_valid}, 32'd0);
`ifdef PPU_RX_STATS_EN
    check_output("wrap_no_drops", {16'd0, drop_count}, 32'd0);
`endif

    // Asynchronous reset with a full, overflowed FIFO.
    for (int k = 0; k < 8; k++) apply_stimulus(1, 32'hC000_0000 + k, 0, 0);
    apply_stimulus(1, 32'hC000_00FF, 0, 0);
    check_output("prereset_ovf", {31'd0, overflow}, 32'd1);
    bus.ppu_send = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check_output("async_rst_full",  {31'd0, bus.ppu_full},  32'd0);
    check_output("async_rst_ovf",   {31'd0, overflow},      32'd0);
`ifdef PPU_RX_STATS_EN
    check_output("async_rst_rx",   {16'd0, rx_count},   32'd0);
    check_output("async_rst_drop", {16'd0, drop_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 32'h3560_0042, 0, 0);
    check_output("post_rst_valid", {31'd0, bus.cmd_valid}, 32'd1);
    check_output("post_rst_head",  head_word(),            32'h3560_0042);

`ifdef PPU_RX_STATS_EN
    // Push-and-pop every cycle until the accepted-word counter must saturate.
    for (int k = 0; k < 65537; k++) apply_stimulus(1, 32'h0100_0000, 0, 1);
    check_output("rx_saturate", {16'd0, rx_count}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
